// File: rtl/seg7_scan_decoder_if.sv
// Scanned 7-segment bus and recovered-digit outputs.
// master drives the pins, slave is the decoder.
interface seg7_scan_decoder_if;
   logic [6:0]  iSEG;
   logic [3:0]  iAN;
   logic [15:0] oBCD;
   logic [3:0]  oVALID;
   logic [3:0]  oERR;
   logic        oUPDATE;
   logic [1:0]  oIDX;

   modport master (
      output iSEG, iAN,
      input  oBCD, oVALID, oERR, oUPDATE, oIDX
   );

   modport slave (
      input  iSEG, iAN,
      output oBCD, oVALID, oERR, oUPDATE, oIDX
   );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a scanned active-low 7-seg bus.
// Optional per-digit staleness timeout: define STALE_TIMEOUT_EN.
module seg7_scan_decoder #(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input logic               iClk,
   input logic               iRst_n,
   seg7_scan_decoder_if.slave bus
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
   localparam logic [10:0] IDLE = 11'h7FF;

   logic [10:0]   s1_q, s2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;

   logic [15:0] bcd_q, bcd_d;
   logic [3:0]  valid_q, valid_d;
   logic [3:0]  err_q, err_d;
   logic        upd_q, upd_d;
   logic [1:0]  idx_q, idx_d;

   logic        one_hot;
   logic [1:0]  an_idx;
   logic        seg_match;
   logic        seg_blank;
   logic [3:0]  seg_val;
   logic        commit;

   // Two-flop synchronizer for anode and segment lines as one word
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         s1_q <= IDLE;
         s2_q <= IDLE;
      end else begin
         s1_q <= {bus.iAN, bus.iSEG};
         s2_q <= s1_q;
      end
   end

   // Anode field: exactly one low bit selects the digit
   always_comb begin
      one_hot = 1'b1;
      an_idx  = 2'd0;
      case (s2_q[10:7])
         4'b1110: an_idx = 2'd0;
         4'b1101: an_idx = 2'd1;
         4'b1011: an_idx = 2'd2;
         4'b0111: an_idx = 2'd3;
         default: one_hot = 1'b0;
      endcase
   end

   // Segment field: active-low pattern to decimal value
   always_comb begin
      seg_match = 1'b1;
      seg_blank = 1'b0;
      seg_val   = 4'd0;
      case (s2_q[6:0])
         7'h40: seg_val = 4'd0;
         7'h79: seg_val = 4'd1;
         7'h24: seg_val = 4'd2;
         7'h30: seg_val = 4'd3;
         7'h19: seg_val = 4'd4;
         7'h12: seg_val = 4'd5;
         7'h02: seg_val = 4'd6;
         7'h78: seg_val = 4'd7;
         7'h00: seg_val = 4'd8;
         7'h10: seg_val = 4'd9;
         7'h7F: begin
            seg_match = 1'b0;
            seg_blank = 1'b1;
         end
         default: seg_match = 1'b0;
      endcase
   end

   // s1 is the value s2 takes next, so compare them for stability
   always_comb begin
      cnt_d  = cnt_q;
      done_d = done_q;
      commit = (cnt_q == CMAX) && !done_q && one_hot;
      if (commit)
         done_d = 1'b1;
      if (s1_q == s2_q) begin
         if (cnt_q != CMAX)
            cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d  = CW'(1);
         done_d = 1'b0;
      end
   end

   // Stability counter and one-commit-per-pattern flag
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

`ifdef STALE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmo_q [4];
   logic [TW-1:0] tmo_d [4];
   logic [3:0]    stale;

   // Per-digit age counters; a commit to the digit restarts it
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         tmo_d[i] = tmo_q[i];
         stale[i] = (tmo_q[i] >= TLAST);
         if (commit && an_idx == 2'(i))
            tmo_d[i] = '0;
         else if (tmo_q[i] != TMAX)
            tmo_d[i] = tmo_q[i] + 1'b1;
      end
   end

   // Age counter registers
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         for (int i = 0; i < 4; i++)
            tmo_q[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++)
            tmo_q[i] <= tmo_d[i];
      end
   end
`endif

   // Output next-state: staleness first so a commit overrides it
   always_comb begin
      bcd_d   = bcd_q;
      valid_d = valid_q;
      err_d   = err_q;
      idx_d   = idx_q;
      upd_d   = 1'b0;
`ifdef STALE_TIMEOUT_EN
      valid_d = valid_d & ~stale;
      err_d   = err_d & ~stale;
`endif
      if (commit) begin
         idx_d = an_idx;
         upd_d = 1'b1;
         if (seg_match) begin
            bcd_d[{an_idx, 2'b00} +: 4] = seg_val;
            valid_d[an_idx] = 1'b1;
            err_d[an_idx]   = 1'b0;
         end else begin
            valid_d[an_idx] = 1'b0;
            err_d[an_idx]   = !seg_blank;
         end
      end
   end

   // Output registers
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         bcd_q   <= '0;
         valid_q <= '0;
         err_q   <= '0;
         upd_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         bcd_q   <= bcd_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         upd_q   <= upd_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.oBCD    = bcd_q;
   assign bus.oVALID  = valid_q;
   assign bus.oERR    = err_q;
   assign bus.oUPDATE = upd_q;
   assign bus.oIDX    = idx_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder.
// Stimulus queues expected commits; a monitor checks each oUPDATE.
module tb_seg7_scan_decoder;

   localparam int N = 16;
   localparam int TMO = 50;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   typedef struct {
      int          c;
      logic [1:0]  idx;
      logic [15:0] bcd;
      logic [3:0]  v;
      logic [3:0]  e;
   } exp_t;

   exp_t q[$];
   exp_t cur;

   seg7_scan_decoder_if bus();

   seg7_scan_decoder #(
      .STABLE_CYCLES(N),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .iClk(clk),
      .iRst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic logic [3:0] vmask(input logic [1:0] i);
`ifdef STALE_TIMEOUT_EN
      return 4'b0001 << i;
`else
      return 4'hF;
`endif
   endfunction

   task automatic apply(input logic [3:0] an, input logic [6:0] seg,
                        input int hold, input bit ex,
                        input logic [1:0] idx, input logic [15:0] bcd,
                        input logic [3:0] v, input logic [3:0] e);
      exp_t t;
      bus.iAN  = an;
      bus.iSEG = seg;
      if (ex) begin
         t.c = cyc + N + 2;
         t.idx = idx;
         t.bcd = bcd;
         t.v = v;
         t.e = e;
         q.push_back(t);
      end
      repeat (hold) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.oUPDATE === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_update", 32'(bus.oIDX), 32'hFF);
         end else begin
            cur = q.pop_front();
            chk("latency", cyc, cur.c);
            chk("idx", 32'(bus.oIDX), 32'(cur.idx));
            chk("bcd", 32'(bus.oBCD), 32'(cur.bcd));
            chk("valid", 32'(bus.oVALID & vmask(cur.idx)),
                32'(cur.v & vmask(cur.idx)));
            chk("err", 32'(bus.oERR & vmask(cur.idx)),
                32'(cur.e & vmask(cur.idx)));
         end
      end
   end

   int c1;

   initial begin
      bus.iAN  = 4'hF;
      bus.iSEG = 7'h7F;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bcd", 32'(bus.oBCD), 0);
      chk("rst_valid", 32'(bus.oVALID), 0);
      chk("rst_upd", 32'(bus.oUPDATE), 0);
      rst_n = 1'b1;

      // idle bus: nothing commits
      repeat (100) @(posedge clk);
      #1;
      chk("idle_bcd", 32'(bus.oBCD), 0);
      chk("idle_valid", 32'(bus.oVALID), 0);
      chk("idle_err", 32'(bus.oERR), 0);

      // single digit, held: one commit only
      apply(4'hE, 7'h24, 60, 1, 2'd0, 16'h0002, 4'h1, 4'h0);

      // scan four digits
      apply(4'hE, 7'h79, 64, 1, 2'd0, 16'h0001, 4'h1, 4'h0);
      apply(4'hD, 7'h30, 64, 1, 2'd1, 16'h0031, 4'h3, 4'h0);
      apply(4'hB, 7'h12, 64, 1, 2'd2, 16'h0531, 4'h7, 4'h0);
      apply(4'h7, 7'h10, 64, 1, 2'd3, 16'h9531, 4'hF, 4'h0);

      // illegal pattern then blank on digit 2
      apply(4'hB, 7'h7A, 40, 1, 2'd2, 16'h9531, 4'hB, 4'h4);
      apply(4'hB, 7'h7F, 40, 1, 2'd2, 16'h9531, 4'hB, 4'h0);

      // glitch one sample short of stable, then real value
      apply(4'hD, 7'h40, N - 1, 0, 2'd0, 16'h0, 4'h0, 4'h0);
      apply(4'hD, 7'h78, 40, 1, 2'd1, 16'h9571, 4'hB, 4'h0);

      // two anodes low: no commit
      apply(4'hC, 7'h00, 40, 0, 2'd0, 16'h0, 4'h0, 4'h0);
      chk("two_an_bcd", 32'(bus.oBCD), 32'h9571);
      chk("two_an_idx", 32'(bus.oIDX), 1);

      // reset in the middle of a stability count
      apply(4'h7, 7'h40, 8, 0, 2'd0, 16'h0, 4'h0, 4'h0);
      rst_n = 1'b0;
      #1;
      chk("midrst_bcd", 32'(bus.oBCD), 0);
      chk("midrst_valid", 32'(bus.oVALID), 0);
      chk("midrst_idx", 32'(bus.oIDX), 0);
      bus.iAN  = 4'hF;
      bus.iSEG = 7'h7F;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply(4'hF, 7'h7F, 20, 0, 2'd0, 16'h0, 4'h0, 4'h0);
      apply(4'h7, 7'h40, 40, 1, 2'd3, 16'h0000, 4'h8, 4'h0);

      // staleness on digit 1
      c1 = cyc + N + 2;
      apply(4'hD, 7'h79, 30, 1, 2'd1, 16'h0010, 4'hA, 4'h0);
      bus.iAN  = 4'hF;
      bus.iSEG = 7'h7F;
      while (cyc < c1 + TMO - 1) @(negedge clk);
      chk("stale_before", 32'(bus.oVALID[1]), 1);
      @(negedge clk);
`ifdef STALE_TIMEOUT_EN
      chk("stale_after", 32'(bus.oVALID[1]), 0);
`else
      chk("stale_after", 32'(bus.oVALID[1]), 1);
`endif
      chk("stale_bcd", 32'(bus.oBCD), 32'h0010);
      repeat (20) @(negedge clk);

      chk("queue_empty", 32'(q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
